// File: rtl/lza_pipe_simd_if.sv
// Operand/result handshake bundle for the SIMD leading-zero counter.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface lza_pipe_simd_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic [WIDTH-1:0]   in_data;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [4*CW-1:0]    out_count;
  logic [3:0]         out_zero;
  logic [1:0]         out_mode;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_mode, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_mode, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_mode, out_tag
  );
endinterface

// File: rtl/lza_pipe_simd.sv
// Pipelined SIMD leading-zero counter: stage 0 counts four WIDTH/4 chunks,
// the last stage merges chunks into 1/2/4 lane counts; elastic valid/ready flow.
module lza_pipe_simd #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  lza_pipe_simd_if.slave bus
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int Q   = WIDTH / 4;
  localparam int QW  = $clog2(Q) + 1;
  localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic [QW-1:0] lzc(input logic [Q-1:0] x);
    logic [QW-1:0] n;
    n = QW'(Q);
    // Scanning upward leaves the position of the highest set bit.
    for (int b = 0; b < Q; b++) begin
      if (x[b]) n = QW'(Q - 1 - b);
    end
    return n;
  endfunction

  // A fully-zero upper half extends the count into the lower half.
  function automatic logic [CW-1:0] mrg(input logic [CW-1:0] hi, input logic [CW-1:0] lo,
                                        input logic [CW-1:0] w);
    return (hi == w) ? (w + lo) : hi;
  endfunction

  logic [QW-1:0]    chunk_cnt [4];
  logic [STAGES:0]  load;
  logic [STAGES-1:0] v_w;
  logic [1:0]       mode_w [STAGES];
  logic [TAG_W-1:0] tag_w [STAGES];
  logic [QW-1:0]    cc_w [MID][4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_chunk
    assign chunk_cnt[gi] = lzc(bus.in_data[gi*Q +: Q]);
  end

  // A stage may load when it is empty or the stage after it is loading.
  always_comb begin
    load = '0;
    load[STAGES] = !v_w[STAGES-1] || bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = !v_w[i] || load[i+1];
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_w[STAGES-1];
  assign bus.out_mode  = mode_w[STAGES-1];
  assign bus.out_tag   = tag_w[STAGES-1];

  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             pv;
    logic [1:0]       pmode;
    logic [TAG_W-1:0] ptag;
    logic [QW-1:0]    pcc [4];
    logic             v_reg;
    logic [1:0]       mode_reg;
    logic [TAG_W-1:0] tag_reg;

    if (gi == 0) begin : g_src_in
      assign pv    = bus.in_valid;
      assign pmode = bus.in_mode;
      assign ptag  = bus.in_tag;
      assign pcc   = chunk_cnt;
    end else begin : g_src_prev
      assign pv    = v_w[gi-1];
      assign pmode = mode_w[gi-1];
      assign ptag  = tag_w[gi-1];
      assign pcc   = cc_w[gi-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg    <= 1'b0;
        mode_reg <= '0;
        tag_reg  <= '0;
      end else if (load[gi]) begin
        v_reg <= pv;
        if (pv) begin
          mode_reg <= pmode;
          tag_reg  <= ptag;
        end
      end
    end

    assign v_w[gi]    = v_reg;
    assign mode_w[gi] = mode_reg;
    assign tag_w[gi]  = tag_reg;

    if (gi < STAGES - 1) begin : g_mid
      logic [QW-1:0] cc_reg [4];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < 4; k++) cc_reg[k] <= '0;
        end else if (load[gi] && pv) begin
          cc_reg <= pcc;
        end
      end

      assign cc_w[gi] = cc_reg;
    end else begin : g_last
      logic [CW-1:0]   c0, c1, c2, c3, h0, h1, f;
      logic [4*CW-1:0] cnt_next;
      logic [3:0]      zero_next;
      logic [4*CW-1:0] cnt_reg;
      logic [3:0]      zero_reg;

      always_comb begin
        c0 = CW'(pcc[0]);
        c1 = CW'(pcc[1]);
        c2 = CW'(pcc[2]);
        c3 = CW'(pcc[3]);
        h0 = mrg(c1, c0, CW'(Q));
        h1 = mrg(c3, c2, CW'(Q));
        f  = mrg(h1, h0, CW'(2 * Q));
        cnt_next  = '0;
        zero_next = '0;
        case (pmode)
          2'b01: begin
            cnt_next[0 +: CW]  = h0;
            cnt_next[CW +: CW] = h1;
            zero_next[0] = (h0 == CW'(2 * Q));
            zero_next[1] = (h1 == CW'(2 * Q));
          end
          2'b10: begin
            cnt_next = {c3, c2, c1, c0};
            zero_next = {c3 == CW'(Q), c2 == CW'(Q), c1 == CW'(Q), c0 == CW'(Q)};
          end
          default: begin
            cnt_next[0 +: CW] = f;
            zero_next[0] = (f == CW'(WIDTH));
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          zero_reg <= '0;
        end else if (load[gi] && pv) begin
          cnt_reg  <= cnt_next;
          zero_reg <= zero_next;
        end
      end

      assign bus.out_count = cnt_reg;
      assign bus.out_zero  = zero_reg;
    end
  end
endmodule

// File: tb/tb_lza_pipe_simd.sv
// Scoreboard bench for lza_pipe_simd: accepted operands queue their expected
// results; a negedge monitor checks handshakes, hold-while-stalled and results.
module tb_lza_pipe_simd;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 8;
  localparam int CW     = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lza_pipe_simd_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
  lza_pipe_simd #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4*CW-1:0]  cnt;
    logic [3:0]       zero;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0, n_err = 0, cyc = 0, last_lat = -1;
  bit ovr_en = 0;
  logic [4*CW-1:0] ovr_cnt;
  logic [3:0] ovr_zero;
  int ready_mode = 0;
  int win_lo = 0, win_hi = 0;
  bit saw_backpressure = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: lanes are scanned from their MSB down, counting zeros.
  function automatic void model(input logic [1:0] m, input logic [63:0] d,
                                output logic [4*CW-1:0] c, output logic [3:0] z);
    int n, lw, cnt;
    n  = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    lw = WIDTH / n;
    c = '0;
    z = '0;
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      while (cnt < lw && !d[k*lw + lw - 1 - cnt]) cnt++;
      c[k*CW +: CW] = CW'(cnt);
      z[k] = (cnt == lw);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 9) < 7);
        default: bus.out_ready = !(cyc >= win_lo && cyc <= win_hi);
      endcase
    end
  end

  // Monitor
  initial begin
    logic [63:0] cur, prev_out;
    bit prev_stall;
    exp_t e;
    prev_stall = 0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        prev_stall = 0;
      end else begin
        cur = {22'b0, bus.out_count, bus.out_zero, bus.out_mode, bus.out_tag};
        chk("in_ready", 64'(bus.in_ready), 64'((sbq.size() < STAGES) || bus.out_ready));
        if (!bus.in_ready) saw_backpressure = 1;
        if (prev_stall) chk("hold_while_stalled", cur, prev_out);
        if (bus.out_valid) begin
          if (sbq.size() == 0) begin
            chk("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
          end else if (bus.out_ready) begin
            e = sbq.pop_front();
            chk("result", cur, {22'b0, e.cnt, e.zero, e.mode, e.tag});
            last_lat = cyc - e.acc_cyc;
            chk("latency_min", 64'(last_lat >= STAGES), 64'd1);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (ovr_en) begin
            e.cnt  = ovr_cnt;
            e.zero = ovr_zero;
          end else begin
            model(bus.in_mode, bus.in_data, e.cnt, e.zero);
          end
          e.mode = bus.in_mode;
          e.tag = bus.in_tag;
          e.acc_cyc = cyc;
          sbq.push_back(e);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out = cur;
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [63:0] d, input logic [7:0] t);
    bit acc;
    int g;
    acc = 0;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_mode = m;
    bus.in_data = d;
    bus.in_tag = t;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = bus.in_ready && !rst;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_exp(input logic [1:0] m, input logic [63:0] d, input logic [7:0] t,
                          input logic [4*CW-1:0] c, input logic [3:0] z);
    ovr_en = 1;
    ovr_cnt = c;
    ovr_zero = z;
    send(m, d, t);
    ovr_en = 0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.in_valid = 1'b0;
    while (sbq.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    idle(2);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [63:0] rdata();
    logic [63:0] d;
    int sh;
    for (int k = 0; k < 4; k++) begin
      sh = $urandom_range(0, 16);
      d[k*16 +: 16] = (sh == 16) ? 16'h0 : (16'($urandom) >> sh);
    end
    if ($urandom_range(0, 9) == 0) d = '0;
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_mode = '0;
    bus.in_data = '0;
    bus.in_tag = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_out_zero",  64'(bus.out_zero), 64'd0);
    chk("rst_out_mode",  64'(bus.out_mode), 64'd0);
    chk("rst_out_tag",   64'(bus.out_tag), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Known vectors with hand-derived expectations
    send_exp(2'b00, 64'h0000_0000_0001_0000, 8'd1, {21'd0, 7'd47}, 4'b0000);
    drain();
    chk("latency_single", 64'(last_lat), 64'(STAGES));
    send_exp(2'b00, 64'h0, 8'd2, {21'd0, 7'd64}, 4'b0001);
    send_exp(2'b00, 64'h8000_0000_0000_0000, 8'd3, 28'd0, 4'b0000);
    send_exp(2'b01, 64'h0000_8000_0000_0000, 8'd4, {7'd0, 7'd0, 7'd16, 7'd32}, 4'b0001);
    send_exp(2'b10, 64'h8000_0001_00F0_0000, 8'd5, {7'd0, 7'd15, 7'd8, 7'd16}, 4'b0001);
    send_exp(2'b11, 64'h0000_0000_0000_00FF, 8'd6, {21'd0, 7'd56}, 4'b0000);
    send_exp(2'b01, 64'h0000_0000_0000_0001, 8'd7, {7'd0, 7'd0, 7'd32, 7'd31}, 4'b0010);
    drain();

    // Back-to-back burst through a 4-cycle output stall
    saw_backpressure = 0;
    win_lo = cyc + 3;
    win_hi = cyc + 6;
    ready_mode = 2;
    for (int t = 0; t < 8; t++) send(2'($urandom_range(0, 3)), rdata(), 8'(t));
    drain();
    chk("backpressure_seen", 64'(saw_backpressure), 64'd1);
    ready_mode = 0;

    // Reset with two operands in flight
    win_lo = 0;
    win_hi = 32'h3fff_ffff;
    ready_mode = 2;
    idle(1);
    send(2'b01, rdata(), 8'hA0);
    send(2'b10, rdata(), 8'hA1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_out_count", 64'(bus.out_count), 64'd0);
    chk("rst2_out_zero",  64'(bus.out_zero), 64'd0);
    chk("rst2_out_tag",   64'(bus.out_tag), 64'd0);
    chk("rst2_in_ready",  64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    idle(3);
    send_exp(2'b10, 64'h0001_0000_8000_0000, 8'hB0, {7'd15, 7'd16, 7'd0, 7'd16}, 4'b0101);
    drain();
    chk("latency_after_rst", 64'(last_lat), 64'(STAGES));

    // Randomised traffic with random output back-pressure
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(2'($urandom_range(0, 3)), rdata(), 8'(i));
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
